// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C target: the protocol state enumeration, the
// bus-level constants for ACK/NACK and R/W, and the address-match rule.
// No ports; imported by i2c_bus_sync and i2c_target.
// -----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        IGNORE
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // The general-call address (0) is never claimed, even if the target
    // were configured with it.
    function automatic logic addrMatch(input logic [6:0] rxAddr,
                                       input logic [6:0] ownAddr);
        return (rxAddr == ownAddr) && (rxAddr != 7'd0);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// -----------------------------------------------------------------------------
// i2c_bus_sync
// Brings the raw SCL/SDA pins into the clk domain and derives bus events.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   scl_in, sda_in  raw asynchronous pin levels
//   scl_rise        one-cycle pulse on a synchronized SCL rising edge
//   scl_fall        one-cycle pulse on a synchronized SCL falling edge
//   start_det       SDA fell while SCL stayed high (START / repeated START)
//   stop_det        SDA rose while SCL stayed high (STOP)
//   sda_s           synchronized SDA level
// -----------------------------------------------------------------------------
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] sclSync_q;
    logic [SYNC_STAGES-1:0] sdaSync_q;
    logic                   sclPrev_q;
    logic                   sdaPrev_q;
    logic                   sclS;

    // Synchronizer chain plus one extra registered copy for edge detection.
    // Everything presets to 1 so that reset looks like an idle bus and
    // cannot fabricate a START or an SCL edge on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_in};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_in};
            sclPrev_q <= sclSync_q[SYNC_STAGES-1];
            sdaPrev_q <= sdaSync_q[SYNC_STAGES-1];
        end
    end

    assign sclS  = sclSync_q[SYNC_STAGES-1];
    assign sda_s = sdaSync_q[SYNC_STAGES-1];

    assign scl_rise = sclS & ~sclPrev_q;
    assign scl_fall = ~sclS & sclPrev_q;

    // SCL must be high in both the current and previous sample so that an
    // SDA change racing an SCL edge is not mistaken for START/STOP.
    assign start_det = sclS & sclPrev_q & sdaPrev_q & ~sda_s;
    assign stop_det  = sclS & sclPrev_q & ~sdaPrev_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// -----------------------------------------------------------------------------
// i2c_target
// I2C target (slave) with a 7-bit address. Written bytes are handed to a local
// byte interface, read bytes are requested from it. SDA is driven open-drain
// (pull-low enable only); SCL is never driven and the clock is never stretched.
// Ports:
//   clk, rst    system clock (>= 8x SCL), synchronous active-high reset
//   scl_in      raw SCL pin level
//   sda_in      raw SDA pin level
//   sda_oe      1 = pull SDA low, 0 = release
//   wr_valid    one-cycle pulse, wr_data holds a freshly received byte
//   wr_data     last received write byte, held until the next wr_valid
//   rd_req      one-cycle pulse, rd_data is sampled in that cycle
//   rd_data     next byte to transmit
//   busy        1 while this target is the addressed party of a transfer
// -----------------------------------------------------------------------------
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [7:0] wr_data,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       busy
);

    logic sclRise;
    logic sclFall;
    logic startDet;
    logic stopDet;
    logic sdaS;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_rise (sclRise),
        .scl_fall (sclFall),
        .start_det(startDet),
        .stop_det (stopDet),
        .sda_s    (sdaS)
    );

    // The ADDR parameter shadows the imported ADDR state name, so the state
    // is always written with its package prefix in this file.
    i2c_state_e state_q;
    logic [2:0] bitCnt_q;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic       rw_q;
    logic       ackDrive_q;
    logic       ackBit_q;
    logic       sdaOe_q;
    logic       wrValid_q;
    logic [7:0] wrData_q;
    logic       rdReq_q;
    logic       busy_q;

    // Receive path: the byte with the bit just sampled on SCL rise, MSB first.
    assign shift_d = {shift_q[6:0], sdaS};

    // Protocol FSM. STOP and START override whatever the current state was
    // doing in the same cycle. SDA is only ever changed in reaction to an
    // SCL fall, so the line never moves while SCL is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bitCnt_q   <= 3'd0;
            shift_q    <= 8'h00;
            rw_q       <= RW_WRITE;
            ackDrive_q <= 1'b0;
            ackBit_q   <= I2C_NACK;
            sdaOe_q    <= 1'b0;
            wrValid_q  <= 1'b0;
            wrData_q   <= 8'h00;
            rdReq_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            wrValid_q <= 1'b0;
            rdReq_q   <= 1'b0;

            if (stopDet) begin
                state_q    <= IDLE;
                bitCnt_q   <= 3'd0;
                ackDrive_q <= 1'b0;
                sdaOe_q    <= 1'b0;
                busy_q     <= 1'b0;
            end else if (startDet) begin
                state_q    <= i2c_pkg::ADDR;
                bitCnt_q   <= 3'd0;
                ackDrive_q <= 1'b0;
                sdaOe_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        sdaOe_q <= 1'b0;
                    end

                    i2c_pkg::ADDR: begin
                        if (sclRise) begin
                            shift_q  <= shift_d;
                            bitCnt_q <= bitCnt_q + 3'd1;
                            if (bitCnt_q == 3'd7) begin
                                if (addrMatch(shift_d[7:1], ADDR)) begin
                                    state_q    <= ADDR_ACK;
                                    rw_q       <= shift_d[0];
                                    ackDrive_q <= 1'b0;
                                    busy_q     <= 1'b1;
                                end else begin
                                    state_q <= IGNORE;
                                    sdaOe_q <= 1'b0;
                                    busy_q  <= 1'b0;
                                end
                            end
                        end
                    end

                    // The first SCL fall ends the 8th bit and starts the ACK
                    // slot; the second ends the ACK slot.
                    ADDR_ACK, WRITE_ACK: begin
                        if (sclFall) begin
                            if (!ackDrive_q) begin
                                sdaOe_q    <= 1'b1;
                                ackDrive_q <= 1'b1;
                            end else begin
                                sdaOe_q    <= 1'b0;
                                ackDrive_q <= 1'b0;
                                bitCnt_q   <= 3'd0;
                                if (state_q == ADDR_ACK && rw_q == RW_READ) begin
                                    rdReq_q <= 1'b1;
                                    state_q <= READ;
                                end else begin
                                    state_q <= WRITE;
                                end
                            end
                        end
                    end

                    WRITE: begin
                        if (sclRise) begin
                            shift_q  <= shift_d;
                            bitCnt_q <= bitCnt_q + 3'd1;
                            if (bitCnt_q == 3'd7) begin
                                wrData_q   <= shift_d;
                                wrValid_q  <= 1'b1;
                                ackDrive_q <= 1'b0;
                                state_q    <= WRITE_ACK;
                            end
                        end
                    end

                    // rd_data is captured in the rd_req cycle and its MSB is
                    // put on the bus at once; later bits follow each SCL fall.
                    READ: begin
                        if (rdReq_q) begin
                            shift_q  <= rd_data;
                            sdaOe_q  <= ~rd_data[7];
                            bitCnt_q <= 3'd0;
                        end else if (sclFall) begin
                            if (bitCnt_q == 3'd7) begin
                                sdaOe_q <= 1'b0;
                                state_q <= READ_ACK;
                            end else begin
                                shift_q  <= {shift_q[6:0], 1'b0};
                                sdaOe_q  <= ~shift_q[6];
                                bitCnt_q <= bitCnt_q + 3'd1;
                            end
                        end
                    end

                    READ_ACK: begin
                        if (sclRise) begin
                            ackBit_q <= sdaS;
                        end else if (sclFall) begin
                            if (ackBit_q == I2C_ACK) begin
                                rdReq_q <= 1'b1;
                                state_q <= READ;
                            end else begin
                                state_q <= IGNORE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end

                    IGNORE: begin
                        sdaOe_q <= 1'b0;
                    end

                    default: begin
                        state_q <= IDLE;
                        sdaOe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe   = sdaOe_q;
    assign wr_valid = wrValid_q;
    assign wr_data  = wrData_q;
    assign rd_req   = rdReq_q;
    assign busy     = busy_q;

endmodule
